// File: rtl/inst_issue_queue_if.sv
// Fetch/decode bundle of the instruction issue queue: fetch push side, backend pop side,
// flush and occupancy. The queue uses the slave modport and its environment the master.
interface inst_issue_queue_if #(
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 32,
    parameter int ECAUSE_W = 7
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [ADDR_W-1:0]   in_pc;
    logic [31:0]         in_inst;
    logic                in_is_exception;
    logic [ECAUSE_W-1:0] in_exception_cause;
    logic                in_pre_is_branch;
    logic                in_pre_taken;
    logic [ADDR_W-1:0]   in_pre_branch_addr;
    logic                send_inst_en;
    logic                out_valid;
    logic [ADDR_W-1:0]   out_pc;
    logic [31:0]         out_inst;
    logic                out_is_exception;
    logic [ECAUSE_W-1:0] out_exception_cause;
    logic                out_pre_is_branch;
    logic                out_pre_taken;
    logic [ADDR_W-1:0]   out_pre_branch_addr;
    logic [CNT_W-1:0]    count;

    modport master (
        output flush, in_valid, in_pc, in_inst, in_is_exception, in_exception_cause,
               in_pre_is_branch, in_pre_taken, in_pre_branch_addr, send_inst_en,
        input  in_ready, out_valid, out_pc, out_inst, out_is_exception, out_exception_cause,
               out_pre_is_branch, out_pre_taken, out_pre_branch_addr, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_inst, in_is_exception, in_exception_cause,
               in_pre_is_branch, in_pre_taken, in_pre_branch_addr, send_inst_en,
        output in_ready, out_valid, out_pc, out_inst, out_is_exception, out_exception_cause,
               out_pre_is_branch, out_pre_taken, out_pre_branch_addr, count
    );
endinterface

// File: rtl/inst_issue_queue.sv
// Fetch-to-decode circular instruction queue with flush. Optional empty-queue bypass
// (zero-latency fetch-to-decode path) is enabled by defining INST_ISSUE_QUEUE_BYPASS_EN.
module inst_issue_queue #(
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 32,
    parameter int ECAUSE_W = 7
) (
    input logic                clk,
    input logic                rst,
    inst_issue_queue_if.slave  q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0]   pc;
        logic [31:0]         inst;
        logic                is_exception;
        logic [ECAUSE_W-1:0] exception_cause;
        logic                pre_is_branch;
        logic                pre_taken;
        logic [ADDR_W-1:0]   pre_branch_addr;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             in_entry;
    entry_t             head;
    entry_t             out_entry;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_next;
    logic               empty;
    logic               full;
    logic               bypass;
    logic               bypass_take;
    logic               push;
    logic               pop;

    assign in_entry = '{pc:              q.in_pc,
                        inst:            q.in_inst,
                        is_exception:    q.in_is_exception,
                        exception_cause: q.in_exception_cause,
                        pre_is_branch:   q.in_pre_is_branch,
                        pre_taken:       q.in_pre_taken,
                        pre_branch_addr: q.in_pre_branch_addr};

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign head  = mem[rd_ptr];

`ifdef INST_ISSUE_QUEUE_BYPASS_EN
    // An instruction arriving at an empty queue is shown immediately; if decode takes it
    // in the same cycle it never occupies a slot.
    assign bypass      = empty & q.in_valid & ~q.flush;
    assign bypass_take = bypass & q.send_inst_en;
`else
    assign bypass      = 1'b0;
    assign bypass_take = 1'b0;
`endif

    assign push       = q.in_valid & ~full & ~q.flush & ~bypass_take;
    assign pop        = q.send_inst_en & ~empty & ~q.flush;
    assign count_next = count_q + CNT_W'(push) - CNT_W'(pop);

    // Empty queue presents a NOP with all side fields cleared.
    always_comb begin
        out_entry      = '0;
        out_entry.inst = 32'h0340_0000;
        if (!empty) begin
            out_entry = head;
        end else if (bypass) begin
            out_entry = in_entry;
        end
    end

    assign q.in_ready            = ~full;
    assign q.out_valid           = ~empty | bypass;
    assign q.out_pc              = out_entry.pc;
    assign q.out_inst            = out_entry.inst;
    assign q.out_is_exception    = out_entry.is_exception;
    assign q.out_exception_cause = out_entry.exception_cause;
    assign q.out_pre_is_branch   = out_entry.pre_is_branch;
    assign q.out_pre_taken       = out_entry.pre_taken;
    assign q.out_pre_branch_addr = out_entry.pre_branch_addr;
    assign q.count               = count_q;

    // Entry storage has no reset; only slots between rd_ptr and wr_ptr are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    // Reset and flush both empty the queue; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (q.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_next;
        end
    end
endmodule

// File: tb/tb_inst_issue_queue.sv
// Directed self-checking bench for inst_issue_queue with hand-computed expectations.
module tb_inst_issue_queue;
    localparam logic [31:0] BASE = 32'h1c00_0000;
    localparam logic [31:0] NOP  = 32'h0340_0000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    inst_issue_queue_if #(.DEPTH(8), .ADDR_W(32), .ECAUSE_W(7)) bus ();

    inst_issue_queue #(.DEPTH(8), .ADDR_W(32), .ECAUSE_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                                 input logic [31:0] inst, input logic send,
                                 input logic flush);
        bus.in_valid           = valid;
        bus.in_pc              = pc;
        bus.in_inst            = inst;
        bus.in_is_exception    = 1'b0;
        bus.in_exception_cause = '0;
        bus.in_pre_is_branch   = 1'b0;
        bus.in_pre_taken       = 1'b0;
        bus.in_pre_branch_addr = '0;
        bus.send_inst_en       = send;
        bus.flush              = flush;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int model_count;
        int head_idx;
        int next_idx;
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("reset_count", 64'(bus.count), 64'd0);
        checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("empty_nop_inst", 64'(bus.out_inst), 64'(NOP));
        checkOutput("empty_pc_zero", 64'(bus.out_pc), 64'd0);

        $display("[TB] single push latency");
        applyStimulus(1'b1, BASE, 32'h02800c0c, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("first_out_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("first_out_pc", 64'(bus.out_pc), 64'(BASE));
        checkOutput("first_out_inst", 64'(bus.out_inst), 64'h02800c0c);
        checkOutput("first_count", 64'(bus.count), 64'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("first_pop_count", 64'(bus.count), 64'd0);

        $display("[TB] fill to full and drain");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, BASE + 32'(4 * i), 32'h1000 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("full_count", 64'(bus.count), 64'd8);
        checkOutput("full_in_ready", 64'(bus.in_ready), 64'd0);
        applyStimulus(1'b1, BASE + 32'h20, 32'h1008, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("ninth_rejected_count", 64'(bus.count), 64'd8);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            #1;
            checkOutput("drain_pc", 64'(bus.out_pc), 64'(BASE + 32'(4 * i)));
            tick();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("drained_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("drained_count", 64'(bus.count), 64'd0);

        $display("[TB] streaming at full with wrap");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, BASE + 32'(4 * i), 32'h2000 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        model_count = 8;
        head_idx    = 0;
        next_idx    = 8;
        for (int c = 0; c < 20; c++) begin
            logic exp_ready;
            exp_ready = (model_count != 8);
            applyStimulus(1'b1, BASE + 32'(4 * next_idx), 32'h2000 + 32'(next_idx), 1'b1, 1'b0);
            #1;
            checkOutput("stream_in_ready", 64'(bus.in_ready), 64'(exp_ready));
            checkOutput("stream_pc", 64'(bus.out_pc), 64'(BASE + 32'(4 * head_idx)));
            tick();
            head_idx++;
            model_count--;
            if (exp_ready) begin
                next_idx++;
                model_count++;
            end
            checkOutput("stream_count", 64'(bus.count), 64'(model_count));
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();

        $display("[TB] flush with concurrent push and pop");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, BASE + 32'(4 * i), 32'h3000 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("preflush_count", 64'(bus.count), 64'd5);
        applyStimulus(1'b1, BASE + 32'h14, 32'h3005, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("flush_count", 64'(bus.count), 64'd0);
        checkOutput("flush_out_valid", 64'(bus.out_valid), 64'd0);
        tick();
        checkOutput("flush_stays_empty", 64'(bus.count), 64'd0);

        $display("[TB] side fields pass through");
        applyStimulus(1'b1, BASE + 32'h40, 32'h0280_0421, 1'b0, 1'b0);
        bus.in_is_exception    = 1'b1;
        bus.in_exception_cause = 7'h08;
        bus.in_pre_is_branch   = 1'b1;
        bus.in_pre_taken       = 1'b1;
        bus.in_pre_branch_addr = BASE + 32'h100;
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("field_pc", 64'(bus.out_pc), 64'(BASE + 32'h40));
        checkOutput("field_inst", 64'(bus.out_inst), 64'h02800421);
        checkOutput("field_exc", 64'(bus.out_is_exception), 64'd1);
        checkOutput("field_cause", 64'(bus.out_exception_cause), 64'h08);
        checkOutput("field_br", 64'(bus.out_pre_is_branch), 64'd1);
        checkOutput("field_taken", 64'(bus.out_pre_taken), 64'd1);
        checkOutput("field_target", 64'(bus.out_pre_branch_addr), 64'(BASE + 32'h100));

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, BASE + 32'(4 * i), 32'h4000 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("prereset_count", 64'(bus.count), 64'd3);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("midreset_count", 64'(bus.count), 64'd0);
        checkOutput("midreset_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("midreset_in_ready", 64'(bus.in_ready), 64'd1);

        $display("[TB] underflow guard");
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("underflow_count", 64'(bus.count), 64'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

`ifdef INST_ISSUE_QUEUE_BYPASS_EN
        $display("[TB] empty-queue bypass");
        applyStimulus(1'b1, BASE + 32'h200, 32'h0280_0777, 1'b1, 1'b0);
        #1;
        checkOutput("bypass_out_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("bypass_out_pc", 64'(bus.out_pc), 64'(BASE + 32'h200));
        checkOutput("bypass_out_inst", 64'(bus.out_inst), 64'h02800777);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("bypass_count", 64'(bus.count), 64'd0);
        checkOutput("bypass_after_valid", 64'(bus.out_valid), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_issue_queue.md
Name: inst_issue_queue

Overview:
- Fetch-to-decode instruction queue on the frontend side of the frontend/backend interface.
- Accepts one fetched instruction per cycle from fetch: pc, inst, exception tag and branch-prediction info.
- Presents the oldest entry to the backend's decode stage and pops it when the backend's ctrl asserts send_inst_en.
- Drops all contents on a branch or exception flush.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- ADDR_W, 32, width of pc and predicted branch address.
- ECAUSE_W, 7, width of exception_cause.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- flush  in  1  branch_flush OR exception_flush; clears the queue.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept an entry this cycle.
- in_pc  in  ADDR_W  instruction pc.
- in_inst  in  32  instruction word.
- in_is_exception  in  1  fetch-side exception (ADEF/TLB) flag.
- in_exception_cause  in  ECAUSE_W  exception code.
- in_pre_is_branch  in  1  predictor marks branch.
- in_pre_taken  in  1  predicted taken.
- in_pre_branch_addr  in  ADDR_W  predicted target.
- send_inst_en  in  1  backend consumes the head entry.
- out_valid  out  1  head entry valid.
- out_pc, out_inst, out_is_exception, out_exception_cause, out_pre_is_branch, out_pre_taken, out_pre_branch_addr  out  as inputs  head entry fields.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage: circular buffer of DEPTH entries.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - count is tracked separately.
- Reset (rst==0 at a clock edge):
  - wr_ptr=rd_ptr=count=0.
  - Entry contents are don't-care.
  - Reset mid-stream discards all entries; in the cycle after reset, out_valid=0 and in_ready=1.
- in_ready = (count != DEPTH). It is combinational from count only and never depends on in_valid.
- push = in_valid & in_ready & ~flush. On push, the entry is written at wr_ptr and wr_ptr increments.
- pop = send_inst_en & out_valid & ~flush. On pop, rd_ptr increments.
- count_next = count + push - pop.
  - Push and pop in the same cycle leave count unchanged.
  - At full, push is blocked by in_ready; a pop that cycle frees a slot, usable from the next cycle.
- out_valid = (count != 0), without bypass; see Optional Feature.
  - Output fields come combinationally from the entry at rd_ptr.
- Empty (out_valid=0):
  - out_inst = 32'h03400000 (NOP).
  - All other output fields = 0.
  - send_inst_en is ignored.
- Latency: an entry pushed in cycle N is visible at the output in cycle N+1.
- Flush has priority over everything:
  - rd_ptr=wr_ptr=count=0 at the next edge.
  - Same-cycle push and pop are discarded.
  - In the flush cycle, outputs still show the pre-flush head, but out_valid must be treated as don't-care by the backend.
- Ordering: strict FIFO; no reordering and no duplicate emission.
- send_inst_en held high while empty causes no underflow; count stays 0.

Optional Feature:
- Macro: INST_ISSUE_QUEUE_BYPASS_EN.
- Defined:
  - When count==0, in_valid=1 and flush=0, the outputs mirror the in_* fields combinationally and out_valid=1.
  - If send_inst_en=1 that cycle, the instruction is consumed without being written; pointers and count are unchanged.
  - Otherwise it is written normally.
  - Empty-to-output latency is 0 cycles.
- Undefined:
  - No combinational in_* to out_* path.
  - Latency is 1 cycle, as described in Behaviour.

Test Plan:
- Reset, then push pc=0x1c000000/inst=0x02800c0c, send_inst_en=0 -> next cycle out_valid=1, out_pc=0x1c000000, count=1; while empty before the push, out_inst=0x03400000.
- Push 8 entries (pc 0x1c000000..0x1c00001c step 4) with no pops -> count=8, in_ready=0; a 9th in_valid is not accepted; popping 8 returns pcs in order, then out_valid=0.
- Fill to 8, then hold in_valid=1 and send_inst_en=1 for 20 cycles -> one pop per cycle, pcs strictly increasing by 4, pointers wrap and count never exceeds 8.
- With 5 entries queued, assert flush together with in_valid=1 and send_inst_en=1 -> next cycle count=0, out_valid=0, no entry from that cycle retained.
- Push pc=0x1c000040 with in_is_exception=1, in_exception_cause=0x08, in_pre_is_branch=1, in_pre_taken=1, in_pre_branch_addr=0x1c000100 -> all fields emerge unchanged at the head.
- Drive rst=0 with 3 entries queued while send_inst_en=1 -> next cycle count=0, out_valid=0, in_ready=1. With INST_ISSUE_QUEUE_BYPASS_EN: on an empty queue, in_valid=1 and send_inst_en=1 -> same-cycle out_valid=1, out_pc=in_pc, count stays 0.
